// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one WIDTH-bit up counter between NREQ requesters.
// Define COUNTER_SCHED_PRESCALE_EN to make each count step last PRESCALE cycles.
module counter_sched #(
    parameter int WIDTH    = 4,
    parameter int NREQ     = 2,
    parameter int PRESCALE = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NREQ-1:0]                         req,
    input  logic [NREQ*WIDTH-1:0]                   len,
    input  logic                                    abort,
    output logic [NREQ-1:0]                         grant,
    output logic                                    busy,
    output logic [WIDTH-1:0]                        q,
    output logic                                    done,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] done_id,
    output logic                                    aborted
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || PRESCALE < 1) begin : g_bad_cfg
        $error("counter_sched: NREQ must be 2..8 and PRESCALE >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   owner;
    logic [IDW-1:0]   pick;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pick_len;
    logic [IDW-1:0]   done_id_r;
    logic             aborted_r;
    logic             found;
    logic             step;
    logic             at_target;
    int               scan;

    assign at_target = (q == target);

    // Search starts at the rotating pointer so the last-served requester drops to lowest priority.
    // NOTE: every variable written here gets a default first, otherwise the tool infers latches.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_len = '0;
        scan     = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan = (int'(ptr) + k) % NREQ;
            if (!found && req[scan]) begin
                found    = 1'b1;
                pick     = IDW'(scan);
                pick_len = len[scan*WIDTH +: WIDTH];
            end
        end
    end

`ifdef COUNTER_SCHED_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_cnt;

    assign step = (pre_cnt == PW'(PRESCALE - 1));

    // Held at zero outside RUN, so every run starts with a full prescale period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (state != RUN || step) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
`else
    assign step = 1'b1;
`endif

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = RUN;
            RUN:     if ((step && at_target) || abort) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q         <= '0;
            target    <= '0;
            owner     <= '0;
            ptr       <= '0;
            done_id_r <= '0;
            aborted_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        q      <= '0;
                        target <= pick_len;
                        owner  <= pick;
                    end
                end
                RUN: begin
                    // Reaching the target wins over a simultaneous abort.
                    if (state_next == DONE) begin
                        done_id_r <= owner;
                        aborted_r <= abort && !at_target;
                    end else if (step) begin
                        q <= q + 1'b1;
                    end
                end
                DONE: begin
                    ptr <= (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        grant   = '0;
        busy    = 1'b0;
        done    = 1'b0;
        aborted = 1'b0;
        case (state)
            RUN: begin
                grant[owner] = 1'b1;
                busy         = 1'b1;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                aborted = aborted_r;
            end
            default: ;
        endcase
    end

    assign done_id = done_id_r;

    grant_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));

endmodule

// File: tb/tb_counter_sched.sv
// Testbench for counter_sched: table-driven runs plus hand sequences, done pulses checked
// against a scoreboard queue of expected run results.
module tb_counter_sched;

    localparam int WIDTH    = 4;
    localparam int NREQ     = 2;
    localparam int PRESCALE = 4;
`ifdef COUNTER_SCHED_PRESCALE_EN
    localparam int PS = PRESCALE;
`else
    localparam int PS = 1;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [1:0] req   = '0;
    logic [7:0] len   = '0;
    logic       abort = 1'b0;
    logic [1:0] grant;
    logic       busy;
    logic [3:0] q;
    logic       done;
    logic [0:0] done_id;
    logic       aborted;

    counter_sched #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .len    (len),
        .abort  (abort),
        .grant  (grant),
        .busy   (busy),
        .q      (q),
        .done   (done),
        .done_id(done_id),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:0] id;
        logic       ab;
        logic [3:0] qv;
        int         cycles;
    } exp_t;

    typedef struct {
        logic [1:0] req;
        logic [3:0] len0;
        logic [3:0] len1;
        int         abort_q;
        logic [1:0] exp_grant;
        logic [0:0] exp_id;
        logic [3:0] exp_q;
        logic       exp_ab;
        int         steps;
        logic       cut;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_err    = 0;
    int   run_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard side: every done pulse pops one expected run and is compared against it.
    always @(negedge clk) begin
        if (!rst) begin
            run_cnt = 0;
        end else begin
            if (grant != 2'b00) run_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 done_id=%0d, expected no done", done_id);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_id", done_id, mon_e.id);
                    check("done_aborted", aborted, mon_e.ab);
                    check("done_q", q, mon_e.qv);
                    check("done_grant", grant, 0);
                    check("done_busy", busy, 1);
                    check("run_cycles", run_cnt, mon_e.cycles);
                end
                run_cnt = 0;
            end
        end
    end

    task automatic wait_grant(input logic [1:0] exp_g);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (grant != 2'b00) break;
        end
        check("grant", grant, exp_g);
        check("q_at_grant", q, 0);
        check("busy_run", busy, 1);
    endtask

    task automatic wait_done(input int abort_q);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            abort = (abort_q >= 0 && grant != 2'b00 && int'(q) == abort_q);
            if (sb.size() == 0) break;
        end
        abort = 1'b0;
        req   = 2'b00;
        if (sb.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout: %0d runs still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic post_check(input logic [0:0] id, input logic [3:0] qv);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_grant", grant, 0);
        check("idle_done", done, 0);
        check("idle_aborted", aborted, 0);
        check("hold_q", q, qv);
        check("hold_done_id", done_id, id);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            req    len0   len1   abq  grant  id    q      ab    steps cut
        vecs[0] = '{2'b01, 4'd5,  4'd0,  -1, 2'b01, 1'b0, 4'd5,  1'b0, 6,  1'b0};
        vecs[1] = '{2'b01, 4'd15, 4'd0,  -1, 2'b01, 1'b0, 4'd15, 1'b0, 16, 1'b0};
        vecs[2] = '{2'b10, 4'd0,  4'd7,  -1, 2'b10, 1'b1, 4'd7,  1'b0, 8,  1'b0};
        vecs[3] = '{2'b01, 4'd10, 4'd0,   3, 2'b01, 1'b0, 4'd3,  1'b1, 4,  1'b1};
        vecs[4] = '{2'b01, 4'd4,  4'd0,   4, 2'b01, 1'b0, 4'd4,  1'b0, 5,  1'b1};
        vecs[5] = '{2'b01, 4'd0,  4'd0,  -1, 2'b01, 1'b0, 4'd0,  1'b0, 1,  1'b0};
        vecs[6] = '{2'b11, 4'd1,  4'd2,  -1, 2'b10, 1'b1, 4'd2,  1'b0, 3,  1'b0};
        vecs[7] = '{2'b11, 4'd3,  4'd3,  -1, 2'b01, 1'b0, 4'd3,  1'b0, 4,  1'b0};
        vecs[8] = '{2'b10, 4'd0,  4'd0,  -1, 2'b10, 1'b1, 4'd0,  1'b0, 1,  1'b0};

        // Reset held with requests pending, then released: requester 0 wins first.
        rst = 1'b0;
        req = 2'b11;
        len = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_q", q, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_aborted", aborted, 0);
        rst = 1'b1;
        sb.push_back('{1'b0, 1'b0, 4'd0, PS});
        wait_grant(2'b01);
        wait_done(-1);
        post_check(1'b0, 4'd0);

        for (int i = 0; i < 9; i++) begin
            len = {vecs[i].len1, vecs[i].len0};
            req = vecs[i].req;
            sb.push_back('{vecs[i].exp_id, vecs[i].exp_ab, vecs[i].exp_q,
                           vecs[i].cut ? (vecs[i].steps - 1) * PS + 1 : vecs[i].steps * PS});
            wait_grant(vecs[i].exp_grant);
            wait_done(vecs[i].abort_q);
            post_check(vecs[i].exp_id, vecs[i].exp_q);
        end

        // Both requesters held: strict alternation with the DONE/IDLE gap between runs.
        len = {4'd3, 4'd2};
        req = 2'b11;
        sb.push_back('{1'b0, 1'b0, 4'd2, 3 * PS});
        sb.push_back('{1'b1, 1'b0, 4'd3, 4 * PS});
        sb.push_back('{1'b0, 1'b0, 4'd2, 3 * PS});
        sb.push_back('{1'b1, 1'b0, 4'd3, 4 * PS});
        wait_grant(2'b01);
        wait_done(-1);
        post_check(1'b1, 4'd3);

        // Reset in the middle of a run: no done pulse, everything back to reset values.
        len = {4'd0, 4'd10};
        req = 2'b01;
        wait_grant(2'b01);
        for (int c = 0; c < 60; c++) begin
            if (q == 4'd4) break;
            @(negedge clk);
        end
        check("q_before_rst", q, 4);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_q", q, 0);
        check("midrst_grant", grant, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_done_id", done_id, 0);
        check("midrst_aborted", aborted, 0);
        req = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        len = {4'd2, 4'd0};
        req = 2'b10;
        sb.push_back('{1'b1, 1'b0, 4'd2, 3 * PS});
        wait_grant(2'b10);
        wait_done(-1);
        post_check(1'b1, 4'd2);

`ifdef COUNTER_SCHED_PRESCALE_EN
        // Prescaled run: each q value is held for PRESCALE cycles.
        len = {4'd0, 4'd1};
        req = 2'b01;
        sb.push_back('{1'b0, 1'b0, 4'd1, 2 * PS});
        wait_grant(2'b01);
        for (int i = 1; i < 2 * PS; i++) begin
            @(negedge clk);
            check("pre_q", q, i / PS);
            check("pre_grant", grant, 2'b01);
        end
        wait_done(-1);
        post_check(1'b0, 4'd1);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
